// File: rtl/cjtag_bridge_unit.sv
// Two-wire cJTAG (OScan1 subset) to four-wire JTAG bridge.
// Oversamples TCKC/TMSC with clk_i, handles escapes/activation and decodes 3-slot scan packets.
module cjtag_bridge_unit (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tckc_i,
  input  logic tmsc_i,
  output logic tmsc_o,
  output logic tmsc_oen,
  output logic tck_o,
  output logic tms_o,
  output logic tdi_o,
  input  logic tdo_i,
  output logic online_o,
  output logic nsp_o
);

  typedef enum logic [1:0] {ST_OFFLINE, ST_OAC, ST_ONLINE} state_e;

  // Activation bits in arrival order, bit i = i-th TMSC bit (OAC, EC, CP, each LSB first).
  localparam logic [11:0] OAC_SEQ = 12'h08C;

  logic [2:0] tckc_sync_q;
  logic [2:0] tmsc_sync_q;
  logic       tckc_s, tckc_rise, tckc_fall;
  logic       tmsc_s, tmsc_edge;

  state_e     state_q;
  logic [3:0] esc_cnt_q, esc_cnt_d;
  logic [3:0] bit_cnt_q;
  logic [1:0] slot_q;
  logic       skip_fall_q;
  logic       tck_q, tms_q, tdi_q, tmsc_out_q, oen_q, online_q, nsp_q;
  logic       esc_hit, esc_select;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tckc_sync_q <= '0;
      tmsc_sync_q <= '0;
    end else begin
      tckc_sync_q <= {tckc_sync_q[1:0], tckc_i};
      tmsc_sync_q <= {tmsc_sync_q[1:0], tmsc_i};
    end
  end

  assign tckc_s    = tckc_sync_q[1];
  assign tckc_rise = tckc_sync_q[1] & ~tckc_sync_q[2];
  assign tckc_fall = ~tckc_sync_q[1] & tckc_sync_q[2];
  assign tmsc_s    = tmsc_sync_q[1];
  assign tmsc_edge = tmsc_sync_q[1] ^ tmsc_sync_q[2];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    esc_cnt_d = esc_cnt_q;
    if (tckc_rise) begin
      esc_cnt_d = 4'd0;
    end else if (tckc_s && tmsc_edge && oen_q && (esc_cnt_q != 4'hF)) begin
      esc_cnt_d = esc_cnt_q + 4'd1;
    end
  end

  assign esc_hit    = tckc_fall && (esc_cnt_q >= 4'd4);
  assign esc_select = esc_cnt_q inside {4'd6, 4'd7};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_OFFLINE;
      esc_cnt_q   <= 4'd0;
      bit_cnt_q   <= 4'd0;
      slot_q      <= 2'd0;
      skip_fall_q <= 1'b0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      tmsc_out_q  <= 1'b0;
      oen_q       <= 1'b1;
      online_q    <= 1'b0;
      nsp_q       <= 1'b1;
    end else begin
      esc_cnt_q <= esc_cnt_d;
      if (!oen_q) tmsc_out_q <= tdo_i;

      if (esc_hit) begin
        state_q     <= esc_select ? ST_OAC : ST_OFFLINE;
        bit_cnt_q   <= 4'd0;
        slot_q      <= 2'd0;
        skip_fall_q <= 1'b0;
        tck_q       <= 1'b0;
        tms_q       <= 1'b1;
        tdi_q       <= 1'b0;
        oen_q       <= 1'b1;
        online_q    <= 1'b0;
        nsp_q       <= 1'b1;
      end else begin
        case (state_q)
          ST_OAC: begin
            if (tckc_rise) begin
              if (tmsc_s != OAC_SEQ[bit_cnt_q]) begin
                state_q   <= ST_OFFLINE;
                bit_cnt_q <= 4'd0;
              end else if (bit_cnt_q == 4'd11) begin
                state_q     <= ST_ONLINE;
                bit_cnt_q   <= 4'd0;
                slot_q      <= 2'd0;
                skip_fall_q <= 1'b1;
                online_q    <= 1'b1;
                nsp_q       <= 1'b0;
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          ST_ONLINE: begin
            if (tckc_rise) begin
              case (slot_q)
                2'd0: begin
                  tdi_q <= ~tmsc_s;
                  tck_q <= 1'b0;
                end
                2'd1: tms_q <= tmsc_s;
                2'd2: tck_q <= 1'b1;
                default: ;
              endcase
            end
            if (tckc_fall) begin
              // The fall that ends the last activation bit is not a packet slot boundary.
              if (skip_fall_q) begin
                skip_fall_q <= 1'b0;
              end else begin
                case (slot_q)
                  2'd0: slot_q <= 2'd1;
                  2'd1: begin
                    slot_q     <= 2'd2;
                    oen_q      <= 1'b0;
                    tmsc_out_q <= tdo_i;
                  end
                  default: begin
                    slot_q <= 2'd0;
                    oen_q  <= 1'b1;
                  end
                endcase
              end
            end
          end
          default: begin
            tck_q <= 1'b0;
            tms_q <= 1'b1;
            tdi_q <= 1'b0;
            oen_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign tmsc_o   = tmsc_out_q;
  assign tmsc_oen = oen_q;
  assign tck_o    = tck_q;
  assign tms_o    = tms_q;
  assign tdi_o    = tdi_q;
  assign online_o = online_q;
  assign nsp_o    = nsp_q;

endmodule

// File: tb/tb_cjtag_bridge_unit.sv
// Self-checking bench for cjtag_bridge_unit: host cJTAG driver, shared TMSC wire,
// 1149.1 TAP model with a 32-bit IDCODE, and queue-based scoreboards for TCK pulses and TDO.
module tb_cjtag_bridge_unit;

  typedef enum logic [3:0] {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDDR,
    SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPDIR
  } tap_e;

  localparam logic [31:0] IDCODE = 32'h1DEAD3FF;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic tckc = 1'b0;
  logic host_tmsc = 1'b1;
  logic tmsc_wire, tmsc_o, tmsc_oen, tck_o, tms_o, tdi_o, tdo_drv, online_o, nsp_o;

  int n_cmp = 0;
  int n_mis = 0;
  int tdo_mode = 0;  // 0 = TAP model, 1 = force 1, 2 = force 0
  logic tap_tdo = 1'b0;
  tap_e tap_st = TLR;
  logic [31:0] tap_dr = '0;
  logic tck_prev = 1'b0;

  logic [1:0] exp_pulse_q[$];
  logic [1:0] obs_pulse_q[$];
  logic       exp_tdo_q[$];

  bit oac_bits [12] = '{0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0};

  assign tmsc_wire = tmsc_oen ? host_tmsc : tmsc_o;
  assign tdo_drv   = (tdo_mode == 0) ? tap_tdo : (tdo_mode == 1);

  cjtag_bridge_unit dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .tckc_i   (tckc),
    .tmsc_i   (tmsc_wire),
    .tmsc_o   (tmsc_o),
    .tmsc_oen (tmsc_oen),
    .tck_o    (tck_o),
    .tms_o    (tms_o),
    .tdi_o    (tdi_o),
    .tdo_i    (tdo_drv),
    .online_o (online_o),
    .nsp_o    (nsp_o)
  );

  always #5 clk = ~clk;

  function automatic tap_e tap_next(input tap_e s, input logic tms);
    case (s)
      TLR:     return tms ? TLR   : RTI;
      RTI:     return tms ? SELDR : RTI;
      SELDR:   return tms ? SELIR : CAPDR;
      CAPDR:   return tms ? EX1DR : SHDR;
      SHDR:    return tms ? EX1DR : SHDR;
      EX1DR:   return tms ? UPDDR : PADR;
      PADR:    return tms ? EX2DR : PADR;
      EX2DR:   return tms ? UPDDR : SHDR;
      UPDDR:   return tms ? SELDR : RTI;
      SELIR:   return tms ? TLR   : CAPIR;
      CAPIR:   return tms ? EX1IR : SHIR;
      SHIR:    return tms ? EX1IR : SHIR;
      EX1IR:   return tms ? UPDIR : PAIR;
      PAIR:    return tms ? EX2IR : PAIR;
      EX2IR:   return tms ? UPDIR : SHIR;
      default: return tms ? SELDR : RTI;
    endcase
  endfunction

  // TAP model: samples TMS/TDI on TCK rise, updates TDO on TCK fall.
  always @(posedge tck_o) begin
    if (tap_st == CAPDR) tap_dr = IDCODE;
    else if (tap_st == SHDR) tap_dr = {tdi_o, tap_dr[31:1]};
    tap_st = tap_next(tap_st, tms_o);
  end

  always @(negedge tck_o) tap_tdo = (tap_st == SHDR) ? tap_dr[0] : 1'b0;

  // Pulse monitor: records {tms, tdi} seen at every tck_o rising edge.
  always @(negedge clk) begin
    if (tck_o === 1'b1 && tck_prev === 1'b0) obs_pulse_q.push_back({tms_o, tdi_o});
    tck_prev = tck_o;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500 us, want finish");
    $fatal(1, "watchdog expired");
  end

  // One TCKC period carrying bit v; samples oen/tmsc_o mid high phase.
  task automatic send_bit(input logic v, output logic oen_s, output logic tmsc_s);
    @(negedge clk);
    host_tmsc = v;
    repeat (4) @(negedge clk);
    tckc = 1'b1;
    repeat (5) @(negedge clk);
    oen_s  = tmsc_oen;
    tmsc_s = tmsc_o;
    repeat (3) @(negedge clk);
    tckc = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic escape(input int n);
    @(negedge clk);
    repeat (4) @(negedge clk);
    tckc = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      host_tmsc = ~host_tmsc;
      repeat (4) @(negedge clk);
    end
    tckc = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic activate();
    logic o, t;
    escape(7);
    for (int k = 0; k < 12; k++) send_bit(oac_bits[k], o, t);
  endtask

  task automatic send_packet(input logic ntdi, input logic tms,
                             output logic [2:0] oen_s, output logic tdo_s);
    logic o0, o1, o2, t;
    exp_pulse_q.push_back({tms, ~ntdi});
    send_bit(ntdi, o0, t);
    send_bit(tms, o1, t);
    send_bit(1'b1, o2, tdo_s);
    oen_s = {o2, o1, o0};
  endtask

  task automatic test_reset();
    logic [6:0] v;
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    v = {tmsc_o, tmsc_oen, tck_o, tms_o, tdi_o, online_o, nsp_o};
    n_cmp++;
    if (v !== 7'b0101001) begin
      n_mis++;
      $display("FAIL reset_values: got %b want 0101001", v);
    end
    rst_i = 1'b0;
    repeat (4) @(negedge clk);
    v = {tmsc_o, tmsc_oen, tck_o, tms_o, tdi_o, online_o, nsp_o};
    n_cmp++;
    if (v !== 7'b0101001) begin
      n_mis++;
      $display("FAIL idle_after_reset: got %b want 0101001", v);
    end
  endtask

  task automatic test_activation();
    logic o, t;
    escape(7);
    for (int k = 0; k < 12; k++) begin
      send_bit(oac_bits[k], o, t);
      if (k == 10) begin
        n_cmp++;
        if (online_o !== 1'b0) begin
          n_mis++;
          $display("FAIL online_before_12th: got %b want 0", online_o);
        end
      end
    end
    n_cmp++;
    if ({online_o, nsp_o} !== 2'b10) begin
      n_mis++;
      $display("FAIL activate_online: got online/nsp %b want 10", {online_o, nsp_o});
    end
    escape(4);
    escape(7);
    for (int k = 0; k < 12; k++) send_bit((k == 4) ? ~oac_bits[k] : oac_bits[k], o, t);
    n_cmp++;
    if ({online_o, nsp_o} !== 2'b01) begin
      n_mis++;
      $display("FAIL bad_5th_bit: got online/nsp %b want 01", {online_o, nsp_o});
    end
  endtask

  task automatic test_packet_decode();
    logic ntdi_v [2] = '{1'b0, 1'b1};
    logic tms_v  [2] = '{1'b1, 1'b0};
    logic tdi_e  [2] = '{1'b1, 1'b0};
    logic [2:0] oe;
    logic td;
    logic [1:0] p_obs, p_exp;
    activate();
    obs_pulse_q.delete();
    exp_pulse_q.delete();
    for (int k = 0; k < 2; k++) begin
      send_packet(ntdi_v[k], tms_v[k], oe, td);
      n_cmp++;
      if ({tdi_o, tms_o} !== {tdi_e[k], tms_v[k]}) begin
        n_mis++;
        $display("FAIL decode_tdi_tms[%0d]: got %b want %b", k, {tdi_o, tms_o}, {tdi_e[k], tms_v[k]});
      end
      n_cmp++;
      if (tck_o !== 1'b1) begin
        n_mis++;
        $display("FAIL decode_tck_high[%0d]: got %b want 1", k, tck_o);
      end
      n_cmp++;
      if (obs_pulse_q.size() != 1) begin
        n_mis++;
        $display("FAIL decode_pulse_count[%0d]: got %0d want 1", k, obs_pulse_q.size());
      end else begin
        p_obs = obs_pulse_q.pop_front();
        p_exp = exp_pulse_q.pop_front();
        n_cmp++;
        if (p_obs !== p_exp) begin
          n_mis++;
          $display("FAIL decode_pulse[%0d]: got tms/tdi %b want %b", k, p_obs, p_exp);
        end
      end
      obs_pulse_q.delete();
      exp_pulse_q.delete();
    end
  endtask

  task automatic test_tdo_return();
    logic [2:0] oe;
    logic td;
    for (int m = 1; m <= 2; m++) begin
      tdo_mode = m;
      send_packet(1'b0, 1'b0, oe, td);
      n_cmp++;
      if (oe !== 3'b011) begin
        n_mis++;
        $display("FAIL tdo_oen_slots[mode %0d]: got slot2..0 %b want 011", m, oe);
      end
      n_cmp++;
      if (td !== (m == 1)) begin
        n_mis++;
        $display("FAIL tdo_value[mode %0d]: got %b want %b", m, td, (m == 1));
      end
      n_cmp++;
      if (tmsc_oen !== 1'b1) begin
        n_mis++;
        $display("FAIL tdo_release[mode %0d]: got oen %b want 1", m, tmsc_oen);
      end
    end
    tdo_mode = 0;
    obs_pulse_q.delete();
    exp_pulse_q.delete();
  endtask

  task automatic test_escapes();
    logic [4:0] v;
    escape(4);
    v = {online_o, nsp_o, tck_o, tms_o, tmsc_oen};
    n_cmp++;
    if (v !== 5'b01011) begin
      n_mis++;
      $display("FAIL deselect: got online/nsp/tck/tms/oen %b want 01011", v);
    end
    activate();
    n_cmp++;
    if (online_o !== 1'b1) begin
      n_mis++;
      $display("FAIL reactivate: got %b want 1", online_o);
    end
    escape(8);
    n_cmp++;
    if ({online_o, nsp_o} !== 2'b01) begin
      n_mis++;
      $display("FAIL reset_escape: got online/nsp %b want 01", {online_o, nsp_o});
    end
    escape(2);
    n_cmp++;
    if (online_o !== 1'b0) begin
      n_mis++;
      $display("FAIL two_toggles_offline: got %b want 0", online_o);
    end
    activate();
    escape(2);
    n_cmp++;
    if (online_o !== 1'b1) begin
      n_mis++;
      $display("FAIL two_toggles_online: got %b want 1", online_o);
    end
    escape(4);
    n_cmp++;
    if (online_o !== 1'b0) begin
      n_mis++;
      $display("FAIL deselect_after_two: got %b want 0", online_o);
    end
  endtask

  task automatic test_reset_mid_packet();
    logic o, t;
    logic [6:0] v;
    activate();
    send_bit(1'b0, o, t);
    send_bit(1'b1, o, t);
    @(negedge clk);
    repeat (4) @(negedge clk);
    tckc = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({tck_o, tmsc_oen} !== 2'b10) begin
      n_mis++;
      $display("FAIL mid_packet_pre: got tck/oen %b want 10", {tck_o, tmsc_oen});
    end
    obs_pulse_q.delete();
    #2 rst_i = 1'b1;
    #1 v = {tmsc_o, tmsc_oen, tck_o, tms_o, tdi_o, online_o, nsp_o};
    n_cmp++;
    if (v !== 7'b0101001) begin
      n_mis++;
      $display("FAIL async_reset: got %b want 0101001", v);
    end
    tckc = 1'b0;
    repeat (4) @(negedge clk);
    rst_i = 1'b0;
    repeat (6) @(negedge clk);
    v = {tmsc_o, tmsc_oen, tck_o, tms_o, tdi_o, online_o, nsp_o};
    n_cmp++;
    if (v !== 7'b0101001 || obs_pulse_q.size() != 0) begin
      n_mis++;
      $display("FAIL post_reset: got %b pulses %0d want 0101001 pulses 0", v, obs_pulse_q.size());
    end
    obs_pulse_q.delete();
    exp_pulse_q.delete();
  endtask

  task automatic test_idcode();
    logic [2:0] oe;
    logic td, tms, e;
    logic [31:0] cap;
    logic [31:0] id;
    logic [1:0] p_obs, p_exp;
    id = IDCODE;
    cap = '0;
    tdo_mode = 0;
    activate();
    obs_pulse_q.delete();
    exp_pulse_q.delete();
    exp_tdo_q.delete();
    for (int k = 0; k < 43; k++) begin
      tms = (k < 5) || (k == 6) || (k == 40) || (k == 41);
      if (k >= 5) exp_tdo_q.push_back((k >= 9 && k <= 40) ? id[k - 9] : 1'b0);
      send_packet(1'b1, tms, oe, td);
      if (k >= 9 && k <= 40) cap[k - 9] = td;
      if (k >= 5) begin
        e = exp_tdo_q.pop_front();
        n_cmp++;
        if (td !== e) begin
          n_mis++;
          $display("FAIL scan_tdo[%0d]: got %b want %b", k, td, e);
        end
      end
      n_cmp++;
      if (obs_pulse_q.size() != 1) begin
        n_mis++;
        $display("FAIL scan_pulse_count[%0d]: got %0d want 1", k, obs_pulse_q.size());
      end else begin
        p_obs = obs_pulse_q.pop_front();
        p_exp = exp_pulse_q.pop_front();
        n_cmp++;
        if (p_obs !== p_exp) begin
          n_mis++;
          $display("FAIL scan_pulse[%0d]: got tms/tdi %b want %b", k, p_obs, p_exp);
        end
      end
      obs_pulse_q.delete();
      exp_pulse_q.delete();
    end
    n_cmp++;
    if (cap !== IDCODE) begin
      n_mis++;
      $display("FAIL idcode_word: got %h want %h", cap, IDCODE);
    end
  endtask

  initial begin
    test_reset();
    test_activation();
    test_packet_decode();
    test_tdo_return();
    test_escapes();
    test_reset_mid_packet();
    test_idcode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/cjtag_bridge_unit.md
# cjtag_bridge_unit

Two-wire cJTAG (IEEE 1149.7 OScan1 subset) to four-wire JTAG converter. It oversamples the TCKC/TMSC pair with a fast system clock, detects escape sequences and the online activation code, and decodes 3-bit OScan1 scan packets into TCK/TMS/TDI pulses for a downstream 1149.1 TAP. It returns the TAP's TDO on the shared TMSC wire. Pad buffering (differential clock receiver, TMSC tristate pad) sits outside this block, in the FPGA top level.

## Interface
- No parameters.
- clk_i  in  1  system clock, 100 MHz nominal; all logic is synchronous to it.
- rst_i  in  1  asynchronous, active-high reset.
- tckc_i  in  1  cJTAG clock, asynchronous to clk_i.
- tmsc_i  in  1  TMSC pad input value, asynchronous.
- tmsc_o  out  1  TMSC value to drive.
- tmsc_oen  out  1  pad output enable, active low: 0 = drive tmsc_o, 1 = high-Z.
- tck_o  out  1  JTAG TCK to the TAP.
- tms_o  out  1  JTAG TMS.
- tdi_o  out  1  JTAG TDI.
- tdo_i  in  1  JTAG TDO from the TAP.
- online_o  out  1  high while in OScan1 online mode.
- nsp_o  out  1  "no scan protocol"; high whenever online_o is low.

## Operation
- **Input conditioning**
  - tckc_i and tmsc_i each pass through a 2-flop synchronizer.
  - A third register on each provides rise/fall detection.
- **Escape detection**
  - While synced TCKC is high, count TMSC transitions in a 4-bit saturating counter.
  - The counter clears on TCKC rise and is evaluated on TCKC fall.
  - Count 0–3: no escape.
  - Count 4–5: deselect; go to OFFLINE.
  - Count 6–7: select; go to OAC and clear the bit counter.
  - Count ≥8: reset; go to OFFLINE.
  - Escapes are honoured in every state.
- **States**
  - OFFLINE (reset state): tck_o=0, tms_o=1, tdi_o=0, tmsc_oen=1.
  - OAC: shift 12 TMSC bits, sampled at TCKC rise. Required order is 0,0,1,1, 0,0,0,1, 0,0,0,0 (OAC=4'b1100, EC=4'b1000, CP=4'b0000, each LSB first).
    - On the 12th bit, a full match goes to ONLINE with slot=0 and online_o=1 on the same clk.
    - Any mismatch goes to OFFLINE.
  - ONLINE: repeating 3-slot packet. The slot counter advances 0→1→2→0 on each TCKC fall.
    - Slot 0 (nTDI), at TCKC rise: tdi_o ← ~tmsc, and tck_o ← 0.
    - Slot 1 (TMS), at TCKC rise: tms_o ← tmsc.
    - Slot 2 (TDO):
      - At the TCKC fall that enters slot 2: tmsc_oen ← 0 and tmsc_o ← tdo_i.
      - At TCKC rise: tck_o ← 1, so the TAP samples TMS/TDI.
      - At the TCKC fall that leaves slot 2: tmsc_oen ← 1.
- **TDO path**
  - tmsc_o is re-sampled from tdo_i every clk while driving.
  - The TAP changes TDO on the tck_o fall in slot 0, well before slot 2.
- **Escape and TMSC drive**
  - An escape seen while the bridge is driving TMSC does not occur; the host is released during slot 2.
  - Transitions of tmsc_i while tmsc_oen=0 are ignored by the escape counter.
- **Leaving ONLINE**
  - Forces tck_o=0 and tms_o=1 (TAP sees TMS high), tmsc_oen=1 and online_o=0.
- **Reset values:** tmsc_o=0, tmsc_oen=1, tck_o=0, tms_o=1, tdi_o=0, online_o=0, nsp_o=1; state OFFLINE, all counters 0.
- **rst_i mid-packet:** immediate return to the reset values, with no partial TCK pulse.

## Timing
- Latency from a pin edge to a registered output is 3–4 clk_i cycles: 2 synchronizer + 1 edge detect + 1 output register.
- TCKC high and low phases must each be ≥ 6 clk_i cycles (TCKC ≤ ~8 MHz at 100 MHz clk_i).
- The host must hold TMSC stable ≥ 4 clk before and after each TCKC rise.
- All outputs are registered and glitch-free.
- tck_o high phase is one TCKC period (slot 2 rise to next slot 0 rise). The low phase is two periods.

## Test plan
- **Reset:** assert rst_i mid-activity -> all outputs take their reset values asynchronously; online_o=0, nsp_o=1.
- **Activation:** 7 TMSC toggles with TCKC high, then OAC bits 0011 0001 0000 -> online_o=1 after the 12th TCKC rise. A wrong 5th bit -> stays offline.
- **Packet decode:** online, send packets (nTDI=0, TMS=1) then (nTDI=1, TMS=0) -> tdi_o=1, tms_o=1, one tck_o pulse; then tdi_o=0, tms_o=0, a second pulse.
- **TDO return:**
  - With tdo_i=1 -> tmsc_oen=0 and tmsc_o=1 only during slot 2, tmsc_oen=1 elsewhere.
  - Repeat with tdo_i=0 -> tmsc_o=0 during slot 2.
- **IDCODE scan:** drive 5 TMS=1 packets, then a DR scan with a TAP model returning 32'h1DEAD3FF -> the captured TMSC slot-2 bits equal 32'h1DEAD3FF, LSB first.
- **Deselect and reset escapes:**
  - Online, 4 toggles -> offline, tck_o=0, tms_o=1.
  - Re-activate, then 8 toggles -> offline.
  - 2 toggles -> no state change.
